// File: rtl/dmem_wait_responder.sv
// Data-memory responder with programmable read/write wait states for the MIPS core.
// Drives stall while an access is pending; pulses ack_o when the access completes.
module dmem_wait_responder #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] writedata_i,
    input  logic        clear_err_i,
    output logic [31:0] readdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] RD_M1 = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_M1 = 4'(WR_LAT - 1);

    state_t              r_state, w_next;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic                w_accept, w_commit, w_we, w_mis;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_wdata;
    logic                w_unused;

    assign w_mis    = (addr_i[1:0] != 2'b00);
    assign w_unused = ^{addr_i[31:ADDR_W+2]};

    // With LAT==1 the commit happens on the acceptance edge, so the commit
    // fields come straight from the inputs in IDLE and from the latches otherwise.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_we      = r_we;
        w_idx     = r_idx;
        w_wdata   = r_wdata;
        ack_o     = 1'b0;
        stall_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i && reset) begin
                    w_accept  = 1'b1;
                    stall_o   = 1'b1;
                    w_we      = memwrite_i;
                    w_idx     = addr_i[ADDR_W+1:2];
                    w_wdata   = writedata_i;
                    w_cnt_nxt = memwrite_i ? WR_M1 : RD_M1;
                    if (w_cnt_nxt == 4'd0) begin
                        w_next   = S_DONE;
                        w_commit = 1'b1;
                    end else begin
                        w_next   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_o   = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next   = S_DONE;
                    w_commit = 1'b1;
                end
            end
            S_DONE: begin
                ack_o  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            readdata_o <= 32'd0;
            err_o      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= memwrite_i;
                r_idx   <= addr_i[ADDR_W+1:2];
                r_wdata <= writedata_i;
            end
            if (w_commit && !w_we)
                readdata_o <= r_mem[w_idx];
            if (w_accept && w_mis)
                err_o <= 1'b1;
            else if (clear_err_i)
                err_o <= 1'b0;
        end
    end

    // Array is not reset; an aborted access never reaches a commit edge.
    always_ff @(posedge clk) begin
        if (w_commit && w_we)
            r_mem[w_idx] <= w_wdata;
    end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench: directed scenarios plus randomized accesses against a word-array model.
module tb_dmem_wait_responder;

    localparam int RDL = 3;
    localparam int WRL = 1;

    logic        clk = 1'b0;
    logic        rst_n, rst3_n;
    logic        req, req3, memwrite, clear_err;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata3;
    logic        ack, stall, err, ack3, stall3, err3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [0:63];
    logic [31:0] m_rd  = 32'd0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.ADDR_W(6), .RD_LAT(RDL), .WR_LAT(WRL)) u_dut (
        .clk(clk), .reset(rst_n), .req_i(req), .memwrite_i(memwrite), .addr_i(addr),
        .writedata_i(wdata), .clear_err_i(clear_err), .readdata_o(rdata), .ack_o(ack),
        .stall_o(stall), .err_o(err));

    dmem_wait_responder #(.ADDR_W(6), .RD_LAT(3), .WR_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst3_n), .req_i(req3), .memwrite_i(memwrite), .addr_i(addr),
        .writedata_i(wdata), .clear_err_i(clear_err), .readdata_o(rdata3), .ack_o(ack3),
        .stall_o(stall3), .err_o(err3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the main DUT; the model is updated from the address/data rules.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic clr);
        int   lat;
        int   idx;
        logic mis;
        lat = we ? WRL : RDL;
        idx = int'(a[7:2]);
        mis = (a[1:0] != 2'b00);
        @(negedge clk);
        req = 1'b1; memwrite = we; addr = a; wdata = d; clear_err = clr;
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
        chk("ack_accept",   32'(ack),   32'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            memwrite = ~we; addr = a + 32'h10; wdata = $urandom; clear_err = 1'b0;
            #1;
            chk("stall_wait", 32'(stall), 32'd1);
            chk("ack_wait",   32'(ack),   32'd0);
        end
        @(negedge clk);
        memwrite = ~we; addr = $urandom; wdata = $urandom; clear_err = 1'b0;
        #1;
        if (mis)      m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (we) m_mem[idx] = d;
        else    m_rd = m_mem[idx];
        chk("ack_done",   32'(ack),   32'd1);
        chk("stall_done", 32'(stall), 32'd0);
        chk("rdata_done", rdata,      m_rd);
        chk("err_done",   32'(err),   32'(m_err));
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; clear_err = 1'b0;
        #1;
        chk("stall_idle", 32'(stall), 32'd0);
        chk("ack_idle",   32'(ack),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0; req3 = 1'b0; clear_err = 1'b0;
        req = 1'b1; memwrite = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;

        // Reset held with a request pending: nothing may happen.
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_ack",   32'(ack),   32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_rdata", rdata,      32'd0);
            chk("rst_err",   32'(err),   32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_accept_stall", 32'(stall), 32'd1);
        @(negedge clk); #1;
        m_mem[4] = 32'hDEADBEEF;
        chk("wr1_ack",   32'(ack),   32'd1);
        chk("wr1_stall", 32'(stall), 32'd0);
        chk("wr1_rdata", rdata,      32'd0);
        idle();

        access(1'b0, 32'h10, 32'h0, 1'b0);
        idle();
        access(1'b1, 32'h8, 32'h55AA55AA, 1'b0);
        access(1'b0, 32'h8, 32'h0, 1'b0);
        chk("b2b_rdata", rdata, 32'h55AA55AA);
        idle();
        idle();

        access(1'b0, 32'h13, 32'h0, 1'b0);
        chk("mis_rdata", rdata, 32'hDEADBEEF);
        access(1'b0, 32'h110, 32'h0, 1'b0);
        chk("alias_rdata", rdata, 32'hDEADBEEF);
        idle();
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0; #1;
        m_err = 1'b0;
        chk("clear_err", 32'(err), 32'd0);
        access(1'b0, 32'h21, 32'h0, 1'b1);
        chk("set_wins", 32'(err), 32'd1);
        idle();

        // Random phase: fill every word, then mixed traffic with aliasing/misalignment.
        for (int i = 0; i < 64; i++)
            access(1'b1, (32'(i) << 2) | ($urandom & 32'hFFFF_FF00), $urandom, 1'b0);
        idle();
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), $urandom, $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        // Abort a pending write on the 3-cycle-latency instance.
        @(negedge clk); rst3_n = 1'b1;
        @(negedge clk); req3 = 1'b1; memwrite = 1'b1; addr = 32'h4; wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("d3_wrA_ack", 32'(ack3), 32'd1);
        @(negedge clk); req3 = 1'b0;
        @(negedge clk); req3 = 1'b1; memwrite = 1'b1; addr = 32'h4; wdata = 32'h12345678;
        #1;
        chk("d3_wrB_stall", 32'(stall3), 32'd1);
        @(negedge clk); req3 = 1'b0; rst3_n = 1'b0;
        #1;
        chk("d3_abort_ack", 32'(ack3), 32'd0);
        @(negedge clk); rst3_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("d3_no_ack", 32'(ack3), 32'd0);
        end
        @(negedge clk); req3 = 1'b1; memwrite = 1'b0; addr = 32'h4;
        repeat (3) @(negedge clk);
        #1;
        chk("d3_rd_ack",   32'(ack3), 32'd1);
        chk("d3_rd_rdata", rdata3,    32'hCAFEF00D);
        @(negedge clk); req3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
